// File: rtl/e_muldiv.sv
// Execute-stage multiply/divide unit owning HI/LO; fixed-latency MULT/MULTU/DIV/DIVU, MTHI/MTLO.
// Define MULDIV_MADD_EN to enable op 6 (MADD) and op 7 (MSUB) accumulate operations.
module e_muldiv #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;
`ifdef MULDIV_MADD_EN
  localparam logic [2:0] OpMadd  = 3'd6;
  localparam logic [2:0] OpMsub  = 3'd7;
`endif

  typedef enum logic {StIdle, StRun} state_e;

  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [2:0]  r_op, w_op_nxt;
  logic [31:0] r_a, w_a_nxt;
  logic [31:0] r_b, w_b_nxt;
  logic [31:0] r_hi, w_hi_nxt;
  logic [31:0] r_lo, w_lo_nxt;
  state_e      w_state;
  logic        w_is_long;

  assign w_state  = (r_cnt != 4'd0) ? StRun : StIdle;
  assign busy     = (w_state == StRun);
`ifdef MULDIV_MADD_EN
  assign w_is_long = (op <= OpDivu) || (op == OpMadd) || (op == OpMsub);
`else
  assign w_is_long = (op <= OpDivu);
`endif
  assign md_stall = busy | (start & w_is_long);
  assign hi       = r_hi;
  assign lo       = r_lo;

  // Datapath works only from the latched operands so live inputs cannot disturb a run.
  logic        w_mul_signed;
  logic [63:0] w_mul_a, w_mul_b, w_prod;
  assign w_mul_signed = (r_op != OpMultu);
  assign w_mul_a = w_mul_signed ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
  assign w_mul_b = w_mul_signed ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
  assign w_prod  = w_mul_a * w_mul_b;

  logic        w_a_neg, w_b_neg, w_div_zero;
  logic [31:0] w_abs_a, w_abs_b, w_den, w_uq, w_ur, w_quot, w_rem;
  assign w_a_neg    = (r_op == OpDiv) & r_a[31];
  assign w_b_neg    = (r_op == OpDiv) & r_b[31];
  assign w_div_zero = (r_b == 32'd0);
  assign w_abs_a    = w_a_neg ? -r_a : r_a;
  assign w_abs_b    = w_b_neg ? -r_b : r_b;
  assign w_den      = w_div_zero ? 32'd1 : w_abs_b;
  assign w_uq       = w_abs_a / w_den;
  assign w_ur       = w_abs_a % w_den;
  // 0x80000000 / -1 falls out naturally: the magnitude quotient negates back to itself.
  assign w_quot     = (w_a_neg ^ w_b_neg) ? -w_uq : w_uq;
  assign w_rem      = w_a_neg ? -w_ur : w_ur;

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_op_nxt  = r_op;
    w_a_nxt   = r_a;
    w_b_nxt   = r_b;
    w_hi_nxt  = r_hi;
    w_lo_nxt  = r_lo;
    if (w_state == StRun) begin
      w_cnt_nxt = r_cnt - 4'd1;
      if (r_cnt == 4'd1) begin
        case (r_op)
          OpMult, OpMultu: {w_hi_nxt, w_lo_nxt} = w_prod;
          OpDiv, OpDivu: begin
            if (!w_div_zero) begin
              w_hi_nxt = w_rem;
              w_lo_nxt = w_quot;
            end
          end
`ifdef MULDIV_MADD_EN
          OpMadd: {w_hi_nxt, w_lo_nxt} = {r_hi, r_lo} + w_prod;
          OpMsub: {w_hi_nxt, w_lo_nxt} = {r_hi, r_lo} - w_prod;
`endif
          default: ;
        endcase
      end
    end else if (start) begin
      case (op)
        OpMult, OpMultu: begin
          w_op_nxt  = op;
          w_a_nxt   = rs_val;
          w_b_nxt   = rt_val;
          w_cnt_nxt = 4'(MUL_CYCLES);
        end
        OpDiv, OpDivu: begin
          w_op_nxt  = op;
          w_a_nxt   = rs_val;
          w_b_nxt   = rt_val;
          w_cnt_nxt = 4'(DIV_CYCLES);
        end
        OpMthi: w_hi_nxt = rs_val;
        OpMtlo: w_lo_nxt = rs_val;
`ifdef MULDIV_MADD_EN
        OpMadd, OpMsub: begin
          w_op_nxt  = op;
          w_a_nxt   = rs_val;
          w_b_nxt   = rt_val;
          w_cnt_nxt = 4'(MUL_CYCLES);
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 4'd0;
      r_op  <= 3'd0;
      r_a   <= 32'd0;
      r_b   <= 32'd0;
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_op  <= w_op_nxt;
      r_a   <= w_a_nxt;
      r_b   <= w_b_nxt;
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
    end
  end

endmodule
